// File: rtl/fetch_sequencer.sv
// Fetch controller: issues halfword reads, assembles 16/32-bit instructions, drives PC advance/redirect.
// IVALID one cycle after the final MACK; ISSUE holds everything stable until IREADY.
module fetch_sequencer #(
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [1:0] LONG_MATCH  = 2'b11
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] iPC,
  output logic        PCLoad,
  output logic        PCEn,
  output logic        ULen,
  output logic [31:0] PCIn,
  output logic        MREQ,
  output logic [31:0] MADDR,
  input  logic [15:0] MRDATA,
  input  logic        MACK,
  output logic        IVALID,
  output logic [31:0] INSTR,
  output logic        ILONG,
  output logic [31:0] IPC,
  input  logic        IREADY,
  input  logic        REDIR,
  input  logic [31:0] REDIR_ADDR,
  output logic        FAULT
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_F_LO, S_F_HI, S_ISSUE, S_FAULT} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_lo, r_hi;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_lo_cap, w_hi_cap, w_long;

  assign w_long = (r_lo[15:14] == LONG_MATCH);

  always_comb begin
    w_state_nxt = r_state;
    w_lo_cap    = 1'b0;
    w_hi_cap    = 1'b0;
    PCLoad      = 1'b0;
    PCEn        = 1'b0;
    ULen        = 1'b0;
    PCIn        = 32'h0;
    MREQ        = 1'b0;
    MADDR       = 32'h0;
    IVALID      = 1'b0;
    INSTR       = 32'h0;
    ILONG       = 1'b0;
    IPC         = 32'h0;
    FAULT       = 1'b0;
    w_cnt_nxt   = '0;

    case (r_state)
      S_IDLE: w_state_nxt = S_F_LO;
      S_F_LO: begin
        if (iPC[0]) begin
          w_state_nxt = S_FAULT;
        end else begin
          MREQ  = 1'b1;
          MADDR = iPC;
          if (MACK) begin
            w_lo_cap    = 1'b1;
            w_state_nxt = (MRDATA[15:14] == LONG_MATCH) ? S_F_HI : S_ISSUE;
          end else if (r_cnt == TO_LAST) begin
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_F_HI: begin
        MREQ  = 1'b1;
        MADDR = iPC + 32'd2;
        if (MACK) begin
          w_hi_cap    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_ISSUE: begin
        IVALID = 1'b1;
        INSTR  = {r_hi, r_lo};
        ILONG  = w_long;
        IPC    = iPC;
        if (IREADY) begin
          PCEn        = 1'b1;
          ULen        = w_long;
          w_state_nxt = S_F_LO;
        end
      end
      S_FAULT: FAULT = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect wins over everything: a same-cycle MACK is dropped, not captured.
    if (REDIR) begin
      PCLoad      = 1'b1;
      PCEn        = 1'b1;
      ULen        = 1'b0;
      PCIn        = REDIR_ADDR;
      w_lo_cap    = 1'b0;
      w_hi_cap    = 1'b0;
      w_state_nxt = S_F_LO;
    end

    if (!REDIR && !MACK && MREQ && (w_state_nxt == r_state))
      w_cnt_nxt = r_cnt + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_lo    <= 16'h0;
      r_hi    <= 16'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (REDIR) begin
        r_lo <= 16'h0;
        r_hi <= 16'h0;
      end else begin
        if (w_lo_cap) begin
          r_lo <= MRDATA;
          r_hi <= 16'h0;
        end
        if (w_hi_cap) r_hi <= MRDATA;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC-block model and a zero-wait table memory.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, PCLoad, PCEn, ULen, MREQ, MACK, IVALID, ILONG, IREADY, REDIR, FAULT;
  logic [31:0] iPC, PCIn, MADDR, INSTR, IPC, REDIR_ADDR;
  logic [15:0] MRDATA;
  logic        mem_en;
  int          n_chk = 0;
  int          n_err = 0;

  logic [31:0] m_addr [8] = '{32'h0, 32'h2, 32'h4, 32'h6, 32'h8, 32'h100, 32'h40, 32'hFFFF_FFFE};
  logic [15:0] m_data [8] = '{16'h1234, 16'hC001, 16'hBEEF, 16'hC123, 16'h9999, 16'hABCD, 16'h0042, 16'hC0DE};

  fetch_sequencer #(.MEM_TIMEOUT(16), .LONG_MATCH(2'b11)) dut (
    .CLK(CLK), .RESET(RESET), .iPC(iPC), .PCLoad(PCLoad), .PCEn(PCEn), .ULen(ULen), .PCIn(PCIn),
    .MREQ(MREQ), .MADDR(MADDR), .MRDATA(MRDATA), .MACK(MACK), .IVALID(IVALID), .INSTR(INSTR),
    .ILONG(ILONG), .IPC(IPC), .IREADY(IREADY), .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  // PC register/incrementer block
  always @(posedge CLK) begin
    if (RESET)     iPC <= 32'h0;
    else if (PCEn) iPC <= PCLoad ? PCIn : iPC + (ULen ? 32'd4 : 32'd2);
  end

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    logic [15:0] d = 16'h0;
    for (int k = 0; k < 8; k++) if (m_addr[k] == a) d = m_data[k];
    return d;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    MACK   = mem_en & MREQ;
    MRDATA = MACK ? mem_rd(MADDR) : 16'h0;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; IREADY = 1'b0; REDIR = 1'b0; REDIR_ADDR = 32'h0;
    MACK = 1'b0; MRDATA = 16'h0; mem_en = 1'b1;
    tick(); tick();
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_ivalid", 32'(IVALID), 32'd0);
    chk("rst_fault", 32'(FAULT), 32'd0);
    chk("rst_pcen", 32'(PCEn), 32'd0);
    chk("rst_instr", INSTR, 32'h0);
    RESET = 1'b0;

    // 16-bit instruction at 0
    tick();
    chk("t1_mreq", 32'(MREQ), 32'd1);
    chk("t1_maddr", MADDR, 32'h0);
    tick();
    chk("t1_ivalid", 32'(IVALID), 32'd1);
    chk("t1_instr", INSTR, 32'h0000_1234);
    chk("t1_ilong", 32'(ILONG), 32'd0);
    chk("t1_ipc", IPC, 32'h0);
    chk("t1_pcen_hold", 32'(PCEn), 32'd0);
    IREADY = 1'b1; #1;
    chk("t1_pcen", 32'(PCEn), 32'd1);
    chk("t1_ulen", 32'(ULen), 32'd0);
    chk("t1_pcload", 32'(PCLoad), 32'd0);

    // 32-bit instruction at 2/4
    tick(); IREADY = 1'b0;
    chk("t2_maddr_lo", MADDR, 32'h2);
    tick();
    chk("t2_maddr_hi", MADDR, 32'h4);
    tick();
    chk("t2_instr", INSTR, 32'hBEEF_C001);
    chk("t2_ilong", 32'(ILONG), 32'd1);
    chk("t2_ipc", IPC, 32'h2);

    // decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_ivalid", 32'(IVALID), 32'd1);
      chk("t3_instr", INSTR, 32'hBEEF_C001);
      chk("t3_mreq", 32'(MREQ), 32'd0);
      chk("t3_pcen", 32'(PCEn), 32'd0);
    end
    IREADY = 1'b1; #1;
    chk("t2_pcen", 32'(PCEn), 32'd1);
    chk("t2_ulen", 32'(ULen), 32'd1);

    // redirect while F_HI is acked in the same cycle
    tick(); IREADY = 1'b0;
    chk("t4_maddr_lo", MADDR, 32'h6);
    tick();
    chk("t4_maddr_hi", MADDR, 32'h8);
    chk("t4_mack", 32'(MACK), 32'd1);
    REDIR = 1'b1; REDIR_ADDR = 32'h100; #1;
    chk("t4_pcload", 32'(PCLoad), 32'd1);
    chk("t4_pcen", 32'(PCEn), 32'd1);
    chk("t4_pcin", PCIn, 32'h100);
    tick(); REDIR = 1'b0;
    chk("t4_ivalid", 32'(IVALID), 32'd0);
    chk("t4_maddr", MADDR, 32'h100);
    tick();
    chk("t4_instr", INSTR, 32'h0000_ABCD);
    chk("t4_ilong", 32'(ILONG), 32'd0);

    // memory never acks: FAULT after exactly 16 wait cycles
    IREADY = 1'b1; mem_en = 1'b0;
    tick(); IREADY = 1'b0;
    chk("t5_maddr", MADDR, 32'h102);
    for (int i = 0; i < 16; i++) begin
      chk("t5_wait_fault", 32'(FAULT), 32'd0);
      chk("t5_wait_mreq", 32'(MREQ), 32'd1);
      tick();
    end
    chk("t5_fault", 32'(FAULT), 32'd1);
    chk("t5_fault_mreq", 32'(MREQ), 32'd0);
    tick();
    chk("t5_sticky", 32'(FAULT), 32'd1);
    mem_en = 1'b1; REDIR = 1'b1; REDIR_ADDR = 32'h40; #1;
    chk("t5_redir_pcload", 32'(PCLoad), 32'd1);
    tick(); REDIR = 1'b0;
    chk("t5_cleared", 32'(FAULT), 32'd0);
    chk("t5_maddr40", MADDR, 32'h40);
    tick();
    chk("t5_instr", INSTR, 32'h0000_0042);
    chk("t5_ipc", IPC, 32'h40);

    // redirect coinciding with an accept, to an odd target
    IREADY = 1'b1; REDIR = 1'b1; REDIR_ADDR = 32'h101; #1;
    chk("t6_ivalid", 32'(IVALID), 32'd1);
    chk("t6_pcload", 32'(PCLoad), 32'd1);
    chk("t6_pcin", PCIn, 32'h101);
    tick(); REDIR = 1'b0; IREADY = 1'b0;
    chk("t6_odd_mreq", 32'(MREQ), 32'd0);
    tick();
    chk("t6_odd_fault", 32'(FAULT), 32'd1);
    chk("t6_odd_mreq2", 32'(MREQ), 32'd0);

    // 32-bit instruction straddling the address wrap
    REDIR = 1'b1; REDIR_ADDR = 32'hFFFF_FFFE;
    tick(); REDIR = 1'b0;
    chk("t6_wrap_lo", MADDR, 32'hFFFF_FFFE);
    tick();
    chk("t6_wrap_hi", MADDR, 32'h0);
    tick();
    chk("t6_wrap_instr", INSTR, 32'h1234_C0DE);
    chk("t6_wrap_ipc", IPC, 32'hFFFF_FFFE);
    IREADY = 1'b1; #1;
    chk("t6_wrap_ulen", 32'(ULen), 32'd1);
    tick(); IREADY = 1'b0;
    chk("t6_wrap_next", MADDR, 32'h2);

    // reset in the middle of a 32-bit fetch
    RESET = 1'b1;
    tick();
    chk("t7_rst_mreq", 32'(MREQ), 32'd0);
    chk("t7_rst_ivalid", 32'(IVALID), 32'd0);
    RESET = 1'b0;
    tick();
    chk("t7_restart", MADDR, 32'h0);
    tick();
    chk("t7_instr", INSTR, 32'h0000_1234);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
